pipelined_add_sub: RTL and testbench

- Parametrised, pipelined carry-select adder/subtractor with a two's-complement overflow flag and optional saturation.
- Next-generation arithmetic primitive for the ODE solver datapath; feeds the integrator accumulate/update stages.
- Carry chain is split across STAGES register stages so wide operands close timing at solver clock rates.
- Uses a valid/ready handshake with full throughput and backpressure.

---
 rtl/add_sub_pkg.sv | 23 ++
 rtl/csel_slice.sv | 34 +++
 rtl/pipelined_add_sub.sv | 180 ++++++++++++++++++
 tb/tb_pipelined_add_sub.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/add_sub_pkg.sv
// Shared constants and helpers for the pipelined carry-select adder/subtractor.
package add_sub_pkg;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  function automatic logic [63:0] sat_max(input int width);
    return (64'd1 << (width - 1)) - 64'd1;
  endfunction

  function automatic logic [63:0] sat_min(input int width);
    return 64'd1 << (width - 1);
  endfunction

  function automatic bit params_ok(input int dw, input int bw, input int st);
    if (dw < 1 || bw < 1 || st < 1) return 1'b0;
    if (dw % (st * bw) != 0) return 1'b0;
    return st <= dw / bw;
  endfunction

endpackage

// File: rtl/csel_slice.sv
// One carry-select slice: two ripple adders (cin 0 and 1) and a late select on the real carry.
module csel_slice
  import add_sub_pkg::*;
#(
  parameter int W = 2
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin_sel,
  output logic [W-1:0] sum,
  output logic         cout
);

  logic [W:0]   c0, c1;
  logic [W-1:0] s0, s1;

  always_comb begin
    c0    = '0;
    c1    = '0;
    s0    = '0;
    s1    = '0;
    c1[0] = 1'b1;
    for (int i = 0; i < W; i++) begin
      s0[i]   = a[i] ^ b[i] ^ c0[i];
      c0[i+1] = (a[i] & b[i]) | (c0[i] & (a[i] ^ b[i]));
      s1[i]   = a[i] ^ b[i] ^ c1[i];
      c1[i+1] = (a[i] & b[i]) | (c1[i] & (a[i] ^ b[i]));
    end
  end

  assign sum  = cin_sel ? s1 : s0;
  assign cout = cin_sel ? c1[W] : c0[W];

endmodule

// File: rtl/pipelined_add_sub.sv
// Pipelined carry-select add/sub: stage k resolves bit group k, upper operand bits ride along
// as skew, and each stage carries a registered group carry into the next.
module pipelined_add_sub
  import add_sub_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int BLOCK_WIDTH = 2,
  parameter int STAGES      = 2,
  parameter int SATURATE    = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  op,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  overflow,
  output logic                  carry_out
);

  localparam int GW = DATA_WIDTH / STAGES;
  localparam int NS = GW / BLOCK_WIDTH;
  localparam int L  = STAGES - 1;

  if (!params_ok(DATA_WIDTH, BLOCK_WIDTH, STAGES)) begin : g_param_err
    $error("pipelined_add_sub: illegal DATA_WIDTH/BLOCK_WIDTH/STAGES combination");
  end

  logic [DATA_WIDTH-1:0] b_cond;
  logic [STAGES-1:0]     vld, stage_en;
  logic                  en_acc;

  assign b_cond = (op == OP_SUB) ? ~b : b;

  // A stage may load when it or any stage downstream of it has room.
  always_comb begin
    stage_en = '0;
    en_acc   = 1'b0;
    for (int k = 0; k < STAGES; k++) begin
      en_acc = out_ready;
      for (int j = k; j < STAGES; j++) en_acc = en_acc | ~vld[j];
      stage_en[k] = en_acc;
    end
  end

  assign in_ready = stage_en[0];

  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    localparam int LO = k * GW;

    logic [GW-1:0]         ga, gb, gsum;
    logic                  gcin, gcout, vin, sa_in, sb_in;
    logic [DATA_WIDTH-1:0] res_in, res_q, res_d;
    logic                  vld_q, vld_d, c_q, c_d, sa_q, sa_d, sb_q, sb_d;

    if (k == 0) begin : g_src
      assign ga     = a[GW-1:0];
      assign gb     = b_cond[GW-1:0];
      assign gcin   = op;
      assign vin    = in_valid;
      assign sa_in  = a[DATA_WIDTH-1];
      assign sb_in  = b_cond[DATA_WIDTH-1];
      assign res_in = '0;
    end else begin : g_src
      assign ga     = g_stg[k-1].g_rem.a_rem_q[GW-1:0];
      assign gb     = g_stg[k-1].g_rem.b_rem_q[GW-1:0];
      assign gcin   = g_stg[k-1].c_q;
      assign vin    = g_stg[k-1].vld_q;
      assign sa_in  = g_stg[k-1].sa_q;
      assign sb_in  = g_stg[k-1].sb_q;
      assign res_in = g_stg[k-1].res_q;
    end

    for (genvar j = 0; j < NS; j++) begin : g_sl
      logic ci, co;
      if (j == 0) begin : g_ci
        assign ci = gcin;
      end else begin : g_ci
        assign ci = g_sl[j-1].co;
      end
      csel_slice #(.W(BLOCK_WIDTH)) u_slice (
        .a      (ga[j*BLOCK_WIDTH +: BLOCK_WIDTH]),
        .b      (gb[j*BLOCK_WIDTH +: BLOCK_WIDTH]),
        .cin_sel(ci),
        .sum    (gsum[j*BLOCK_WIDTH +: BLOCK_WIDTH]),
        .cout   (co)
      );
    end
    assign gcout = g_sl[NS-1].co;

    // Unprocessed upper operand bits, right-aligned so the next group is always at bit 0.
    if (k < STAGES - 1) begin : g_rem
      localparam int REM = DATA_WIDTH - (k + 1) * GW;
      logic [REM-1:0] a_src, b_src, a_rem_q, a_rem_d, b_rem_q, b_rem_d;

      if (k == 0) begin : g_src
        assign a_src = a[DATA_WIDTH-1:GW];
        assign b_src = b_cond[DATA_WIDTH-1:GW];
      end else begin : g_src
        assign a_src = g_stg[k-1].g_rem.a_rem_q[REM+GW-1:GW];
        assign b_src = g_stg[k-1].g_rem.b_rem_q[REM+GW-1:GW];
      end

      always_comb begin
        a_rem_d = a_rem_q;
        b_rem_d = b_rem_q;
        if (stage_en[k]) begin
          a_rem_d = a_src;
          b_rem_d = b_src;
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_rem_q <= '0;
          b_rem_q <= '0;
        end else begin
          a_rem_q <= a_rem_d;
          b_rem_q <= b_rem_d;
        end
      end
    end

    always_comb begin
      vld_d = vld_q;
      c_d   = c_q;
      sa_d  = sa_q;
      sb_d  = sb_q;
      res_d = res_q;
      if (stage_en[k]) begin
        vld_d           = vin;
        c_d             = gcout;
        sa_d            = sa_in;
        sb_d            = sb_in;
        res_d           = res_in;
        res_d[LO +: GW] = gsum;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_q <= 1'b0;
        c_q   <= 1'b0;
        sa_q  <= 1'b0;
        sb_q  <= 1'b0;
        res_q <= '0;
      end else begin
        vld_q <= vld_d;
        c_q   <= c_d;
        sa_q  <= sa_d;
        sb_q  <= sb_d;
        res_q <= res_d;
      end
    end

    assign vld[k] = vld_q;
  end

  logic [DATA_WIDTH-1:0] raw;
  logic                  sa_o, sb_o;

  assign raw       = g_stg[L].res_q;
  assign sa_o      = g_stg[L].sa_q;
  assign sb_o      = g_stg[L].sb_q;
  assign out_valid = vld[L];
  assign carry_out = g_stg[L].c_q;

  // Outputs decode purely from the last stage registers, so they hold while stalled.
  always_comb begin
    overflow = (sa_o == sb_o) && (raw[DATA_WIDTH-1] != sa_o);
    result   = raw;
    if (SATURATE != 0 && overflow)
      result = sa_o ? DATA_WIDTH'(sat_min(DATA_WIDTH)) : DATA_WIDTH'(sat_max(DATA_WIDTH));
  end

endmodule

// File: tb/tb_pipelined_add_sub.sv
// Bench: directed vector table, randomized backpressured stream against an arithmetic model,
// and an asynchronous reset landing mid-stream.
module tb_pipelined_add_sub;

  localparam int DW = 16;
  localparam int ST = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          op = 1'b0;
  logic          out_ready = 1'b1;
  logic [DW-1:0] a = '0;
  logic [DW-1:0] b = '0;

  logic          in_ready, out_valid, overflow, carry_out;
  logic [DW-1:0] result;
  logic          in_ready_s, out_valid_s, overflow_s, carry_out_s;
  logic [DW-1:0] result_s;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pipelined_add_sub #(.DATA_WIDTH(DW), .BLOCK_WIDTH(2), .STAGES(ST), .SATURATE(0)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .overflow(overflow), .carry_out(carry_out)
  );

  pipelined_add_sub #(.DATA_WIDTH(DW), .BLOCK_WIDTH(4), .STAGES(ST), .SATURATE(1)) dut_s (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s), .op(op),
    .a(a), .b(b), .out_valid(out_valid_s), .out_ready(out_ready), .result(result_s),
    .overflow(overflow_s), .carry_out(carry_out_s)
  );

  typedef struct {
    logic          op;
    logic [DW-1:0] a, b, res, res_s;
    logic          ovf, co;
  } vec_t;

  typedef struct {
    logic [DW-1:0] res, res_s;
    logic          ovf, co;
  } exp_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Reference: exact integer arithmetic, then range test for overflow.
  function automatic exp_t model(input logic o, input logic [DW-1:0] x, input logic [DW-1:0] y);
    exp_t e;
    int sx, sy, s, ux, uy;
    sx = $signed(x);
    sy = $signed(y);
    ux = int'(x);
    uy = int'(y);
    s  = o ? sx - sy : sx + sy;
    e.res   = s[DW-1:0];
    e.ovf   = (s > 32767) || (s < -32768);
    e.co    = o ? (ux >= uy) : (ux + uy > 65535);
    e.res_s = e.ovf ? ((s > 0) ? 16'h7FFF : 16'h8000) : e.res;
    return e;
  endfunction

  task automatic run_one(input string tag, input vec_t v);
    int lat;
    @(negedge clk);
    op = v.op; a = v.a; b = v.b; in_valid = 1'b1; out_ready = 1'b1;
    #1 chk({tag, "_in_ready"}, in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_latency"}, lat, ST);
    chk({tag, "_result"}, result, v.res);
    chk({tag, "_overflow"}, overflow, v.ovf);
    chk({tag, "_carry"}, carry_out, v.co);
    chk({tag, "_sat_result"}, result_s, v.res_s);
    chk({tag, "_sat_overflow"}, overflow_s, v.ovf);
  endtask

  vec_t tbl[8];
  exp_t expq[$];
  int   pat[6] = '{1, 0, 0, 1, 1, 0};

  initial begin
    exp_t          e;
    vec_t          v;
    int            sent, rcvd, cyc, occ;
    logic          stall, cur_op;
    logic [DW-1:0] cur_a, cur_b, prev_res, prev_res_s;

    //          op    a         b         res       res_s     ovf   co
    tbl[0] = '{1'b0, 16'h00FF, 16'h0001, 16'h0100, 16'h0100, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 16'h7FFF, 16'h0001, 16'h8000, 16'h7FFF, 1'b1, 1'b0};
    tbl[2] = '{1'b1, 16'h8000, 16'h0001, 16'h7FFF, 16'h8000, 1'b1, 1'b1};
    tbl[3] = '{1'b1, 16'h0005, 16'h0007, 16'hFFFE, 16'hFFFE, 1'b0, 1'b0};
    tbl[4] = '{1'b1, 16'h0007, 16'h0005, 16'h0002, 16'h0002, 1'b0, 1'b1};
    tbl[5] = '{1'b1, 16'h0000, 16'h8000, 16'h8000, 16'h7FFF, 1'b1, 1'b0};
    tbl[6] = '{1'b0, 16'h8000, 16'hFFFF, 16'h7FFF, 16'h8000, 1'b1, 1'b1};
    tbl[7] = '{1'b0, 16'hFFFF, 16'h0001, 16'h0000, 16'h0000, 1'b0, 1'b1};

    // Reset state
    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", result, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_carry", carry_out, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("rst_in_ready", in_ready, 1);

    for (int i = 0; i < 8; i++) run_one($sformatf("vec%0d", i), tbl[i]);

    // Randomized back-to-back stream under a fixed backpressure pattern
    sent = 0; rcvd = 0; cyc = 0; occ = 0; stall = 1'b0;
    prev_res = '0; prev_res_s = '0;
    cur_op = 1'($urandom_range(0, 1)); cur_a = 16'($urandom); cur_b = 16'($urandom);
    while (rcvd < 16 && cyc < 300) begin
      @(negedge clk);
      out_ready = pat[cyc % 6][0];
      in_valid  = (sent < 16);
      op = cur_op; a = cur_a; b = cur_b;
      #1;
      if (stall) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_result", result, prev_res);
        chk("stall_sat_result", result_s, prev_res_s);
      end
      chk("stream_in_ready", in_ready, !(occ == ST && !out_ready));
      chk("stream_sat_in_ready", in_ready_s, in_ready);
      chk("stream_sat_valid", out_valid_s, out_valid);
      if (out_valid && out_ready) begin
        if (expq.size() == 0) begin
          chk("stream_extra_beat", expq.size(), 1);
        end else begin
          e = expq.pop_front();
          chk("stream_result", result, e.res);
          chk("stream_overflow", overflow, e.ovf);
          chk("stream_carry", carry_out, e.co);
          chk("stream_sat_result", result_s, e.res_s);
        end
        rcvd++;
        occ--;
      end
      if (in_valid && in_ready) begin
        expq.push_back(model(cur_op, cur_a, cur_b));
        sent++;
        occ++;
        cur_op = 1'($urandom_range(0, 1)); cur_a = 16'($urandom); cur_b = 16'($urandom);
      end
      stall      = out_valid && !out_ready;
      prev_res   = result;
      prev_res_s = result_s;
      cyc++;
    end
    chk("stream_count", rcvd, 16);
    chk("stream_leftover", expq.size(), 0);
    @(negedge clk);
    in_valid = 1'b0;

    // Two beats in flight, then an asynchronous reset between edges
    @(negedge clk);
    out_ready = 1'b0; op = 1'b0; a = 16'h0001; b = 16'h0002; in_valid = 1'b1;
    @(negedge clk);
    a = 16'h0003; b = 16'h0004;
    @(negedge clk);
    in_valid = 1'b0;
    chk("mid_pre_valid", out_valid, 1);
    chk("mid_pre_result", result, 16'h0003);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_result", result, 0);
    chk("mid_rst_carry", carry_out, 0);
    chk("mid_rst_sat_result", result_s, 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", in_ready, 1);
    chk("post_rst_valid", out_valid, 0);
    v = '{1'b0, 16'h1234, 16'h0101, 16'h1335, 16'h1335, 1'b0, 1'b0};
    run_one("post_rst", v);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
